// File: rtl/ahb_manager_arbiter.sv
// ahb_manager_arbiter
//   Two-manager AHB-Lite arbiter in front of ahb_multiplexor.
//   M0 = CPU, M1 = debug controller. Each manager port has a one-deep
//   address-phase capture register. A manager therefore only sees its address
//   accepted once the arbiter can either issue it or hold it.
//
//   Port summary
//     clk, nrst              system clock, async active-low reset
//     m1_lock                M1 wins every arbitration it takes part in
//     mN_h* (N=0,1)          manager address/data phase inputs
//     mN_hrdata/hready/hresp per-manager responses
//     s_h*                   towards ahb_multiplexor (address phase + hwdata)
//     s_hrdata/hready/hresp  responses from ahb_multiplexor
//
//   Port states: FREE (hready=1), PEND (captured, hready=0),
//   DATA (owns the data phase, hready=s_hready).
module ahb_manager_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              m1_lock,

  input  logic [ADDR_W-1:0] m0_haddr,
  input  logic [2:0]        m0_hburst,
  input  logic [2:0]        m0_hsize,
  input  logic [1:0]        m0_htrans,
  input  logic              m0_hwrite,
  input  logic [DATA_W-1:0] m0_hwdata,
  output logic [DATA_W-1:0] m0_hrdata,
  output logic              m0_hready,
  output logic              m0_hresp,

  input  logic [ADDR_W-1:0] m1_haddr,
  input  logic [2:0]        m1_hburst,
  input  logic [2:0]        m1_hsize,
  input  logic [1:0]        m1_htrans,
  input  logic              m1_hwrite,
  input  logic [DATA_W-1:0] m1_hwdata,
  output logic [DATA_W-1:0] m1_hrdata,
  output logic              m1_hready,
  output logic              m1_hresp,

  output logic [ADDR_W-1:0] s_haddr,
  output logic [2:0]        s_hburst,
  output logic [2:0]        s_hsize,
  output logic [1:0]        s_htrans,
  output logic              s_hwrite,
  output logic [DATA_W-1:0] s_hwdata,
  input  logic [DATA_W-1:0] s_hrdata,
  input  logic              s_hready,
  input  logic              s_hresp
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  // Registered state
  logic [1:0]             pend_v_q, pend_v_d;
  logic [1:0][ADDR_W-1:0] pend_haddr_q, pend_haddr_d;
  logic [1:0][2:0]        pend_hburst_q, pend_hburst_d;
  logic [1:0][2:0]        pend_hsize_q, pend_hsize_d;
  logic [1:0][1:0]        pend_htrans_q, pend_htrans_d;
  logic [1:0]             pend_hwrite_q, pend_hwrite_d;
  logic                   dp_v_q, dp_v_d;
  logic                   dp_own_q, dp_own_d;
  logic                   rr_last_q, rr_last_d;
  logic [ADDR_W-1:0]      hold_haddr_q, hold_haddr_d;
  logic [2:0]             hold_hburst_q, hold_hburst_d;
  logic [2:0]             hold_hsize_q, hold_hsize_d;
  logic                   hold_hwrite_q, hold_hwrite_d;

  // Live manager signals, indexed by port
  logic [1:0][ADDR_W-1:0] live_haddr;
  logic [1:0][2:0]        live_hburst;
  logic [1:0][2:0]        live_hsize;
  logic [1:0][1:0]        live_htrans;
  logic [1:0]             live_hwrite;

  assign live_haddr  = {m1_haddr, m0_haddr};
  assign live_hburst = {m1_hburst, m0_hburst};
  assign live_hsize  = {m1_hsize, m0_hsize};
  assign live_htrans = {m1_htrans, m0_htrans};
  assign live_hwrite = {m1_hwrite, m0_hwrite};

  logic [1:0] port_hready;
  logic [1:0] acc;
  logic [1:0] cand;
  logic [1:0] issue;
  logic [1:0] capture;
  logic       any_cand;
  logic       win;

  logic [ADDR_W-1:0] win_haddr;
  logic [2:0]        win_hburst;
  logic [2:0]        win_hsize;
  logic [1:0]        win_htrans;
  logic              win_hwrite;

  // A pending port must stall; the data-phase owner follows the bus.
  assign port_hready[0] = pend_v_q[0] ? 1'b0 :
                          (dp_v_q && !dp_own_q) ? s_hready : 1'b1;
  assign port_hready[1] = pend_v_q[1] ? 1'b0 :
                          (dp_v_q && dp_own_q) ? s_hready : 1'b1;

  assign acc      = port_hready & {m1_htrans[1], m0_htrans[1]};
  // Arbitration only happens on cycles where the bus can take an address.
  assign cand     = s_hready ? (pend_v_q | acc) : 2'b00;
  assign any_cand = |cand;

  always_comb begin
    win = 1'b0;
    if (cand[1] && (m1_lock || !cand[0])) begin
      win = 1'b1;
    end else if (cand == 2'b11) begin
      // Tie: alternate away from the last winner, or fixed M1 priority.
      win = ROUND_ROBIN ? ~rr_last_q : 1'b1;
    end
  end

  always_comb begin
    if (pend_v_q[win]) begin
      win_haddr  = pend_haddr_q[win];
      win_hburst = pend_hburst_q[win];
      win_hsize  = pend_hsize_q[win];
      win_htrans = pend_htrans_q[win];
      win_hwrite = pend_hwrite_q[win];
    end else begin
      win_haddr  = live_haddr[win];
      win_hburst = live_hburst[win];
      win_hsize  = live_hsize[win];
      win_htrans = live_htrans[win];
      win_hwrite = live_hwrite[win];
    end
  end

  assign issue[0]   = any_cand && !win;
  assign issue[1]   = any_cand && win;
  // Any accepted live address that is not issued this cycle must be held.
  assign capture    = acc & ~issue;

  always_comb begin
    pend_v_d      = (pend_v_q & ~issue) | capture;
    pend_haddr_d  = pend_haddr_q;
    pend_hburst_d = pend_hburst_q;
    pend_hsize_d  = pend_hsize_q;
    pend_htrans_d = pend_htrans_q;
    pend_hwrite_d = pend_hwrite_q;
    for (int n = 0; n < 2; n++) begin
      if (capture[n]) begin
        pend_haddr_d[n]  = live_haddr[n];
        pend_hburst_d[n] = live_hburst[n];
        pend_hsize_d[n]  = live_hsize[n];
        pend_htrans_d[n] = live_htrans[n];
        pend_hwrite_d[n] = live_hwrite[n];
      end
    end

    dp_v_d        = dp_v_q;
    dp_own_d      = dp_own_q;
    rr_last_d     = rr_last_q;
    hold_haddr_d  = hold_haddr_q;
    hold_hburst_d = hold_hburst_q;
    hold_hsize_d  = hold_hsize_q;
    hold_hwrite_d = hold_hwrite_q;
    if (s_hready) begin
      dp_v_d = any_cand;
      if (any_cand) begin
        dp_own_d      = win;
        rr_last_d     = win;
        hold_haddr_d  = win_haddr;
        hold_hburst_d = win_hburst;
        hold_hsize_d  = win_hsize;
        hold_hwrite_d = win_hwrite;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_v_q      <= '0;
      pend_haddr_q  <= '0;
      pend_hburst_q <= '0;
      pend_hsize_q  <= '0;
      pend_htrans_q <= '0;
      pend_hwrite_q <= '0;
      dp_v_q        <= 1'b0;
      dp_own_q      <= 1'b0;
      rr_last_q     <= 1'b1;
      hold_haddr_q  <= '0;
      hold_hburst_q <= '0;
      hold_hsize_q  <= '0;
      hold_hwrite_q <= 1'b0;
    end else begin
      pend_v_q      <= pend_v_d;
      pend_haddr_q  <= pend_haddr_d;
      pend_hburst_q <= pend_hburst_d;
      pend_hsize_q  <= pend_hsize_d;
      pend_htrans_q <= pend_htrans_d;
      pend_hwrite_q <= pend_hwrite_d;
      dp_v_q        <= dp_v_d;
      dp_own_q      <= dp_own_d;
      rr_last_q     <= rr_last_d;
      hold_haddr_q  <= hold_haddr_d;
      hold_hburst_q <= hold_hburst_d;
      hold_hsize_q  <= hold_hsize_d;
      hold_hwrite_q <= hold_hwrite_d;
    end
  end

  // Without an issue this cycle the bus sees IDLE over the last address,
  // which also keeps the address stable through wait states.
  assign s_haddr  = any_cand ? win_haddr  : hold_haddr_q;
  assign s_hburst = any_cand ? win_hburst : hold_hburst_q;
  assign s_hsize  = any_cand ? win_hsize  : hold_hsize_q;
  assign s_hwrite = any_cand ? win_hwrite : hold_hwrite_q;
  assign s_htrans = any_cand ? win_htrans : HTRANS_IDLE;
  assign s_hwdata = dp_own_q ? m1_hwdata : m0_hwdata;

  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign m0_hready = port_hready[0];
  assign m1_hready = port_hready[1];
  assign m0_hresp  = dp_v_q && !dp_own_q && s_hresp;
  assign m1_hresp  = dp_v_q &&  dp_own_q && s_hresp;

endmodule

// File: tb/tb_ahb_manager_arbiter.sv
module tb_ahb_manager_arbiter;

  logic        clk;
  logic        nrst;
  logic        m1_lock;
  logic [31:0] m0_haddr, m1_haddr;
  logic [2:0]  m0_hburst, m1_hburst, m0_hsize, m1_hsize;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hready, m1_hready, m0_hresp, m1_hresp;
  logic [31:0] s_haddr;
  logic [2:0]  s_hburst, s_hsize;
  logic [1:0]  s_htrans;
  logic        s_hwrite;
  logic [31:0] s_hwdata;
  logic [31:0] s_hrdata;
  logic        s_hready, s_hresp;

  int n_checks = 0;
  int n_errors = 0;

  ahb_manager_arbiter #(.ROUND_ROBIN(1'b1), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .nrst(nrst), .m1_lock(m1_lock),
    .m0_haddr(m0_haddr), .m0_hburst(m0_hburst), .m0_hsize(m0_hsize),
    .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hwdata(m0_hwdata),
    .m0_hrdata(m0_hrdata), .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_hburst(m1_hburst), .m1_hsize(m1_hsize),
    .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hwdata(m1_hwdata),
    .m1_hrdata(m1_hrdata), .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_hburst(s_hburst), .s_hsize(s_hsize),
    .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hwdata(s_hwdata),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // outputs are sampled well before the next rising edge
  task automatic settle();
    #4;
  endtask

  task automatic idle_inputs();
    m1_lock   = 1'b0;
    m0_haddr  = '0; m1_haddr  = '0;
    m0_hburst = '0; m1_hburst = '0;
    m0_hsize  = 3'd2; m1_hsize = 3'd2;
    m0_htrans = 2'b00; m1_htrans = 2'b00;
    m0_hwrite = 1'b0; m1_hwrite = 1'b0;
    m0_hwdata = '0; m1_hwdata = '0;
    s_hrdata  = '0; s_hready = 1'b1; s_hresp = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    nrst = 1'b0;
    s_hresp = 1'b1;
    // 1. reset state
    #3;
    chk("rst_htrans", 32'(s_htrans), 32'h0);
    chk("rst_m0_hready", 32'(m0_hready), 32'h1);
    chk("rst_m1_hready", 32'(m1_hready), 32'h1);
    chk("rst_m0_hresp", 32'(m0_hresp), 32'h0);
    chk("rst_m1_hresp", 32'(m1_hresp), 32'h0);
    s_hresp = 1'b0;
    tick();
    nrst = 1'b1;
    tick();
    tick();
    settle();
    chk("idle_htrans", 32'(s_htrans), 32'h0);
    tick();

    // 2. uncontended M0 read
    m0_haddr = 32'h100; m0_htrans = 2'b10;
    settle();
    chk("t2_haddr", s_haddr, 32'h100);
    chk("t2_htrans", 32'(s_htrans), 32'h2);
    tick();
    m0_htrans = 2'b00; s_hready = 1'b0; s_hrdata = 32'hDEAD_0001;
    settle();
    chk("t2_m0_hready_wait", 32'(m0_hready), 32'h0);
    chk("t2_m0_hrdata", m0_hrdata, 32'hDEAD_0001);
    chk("t2_htrans_wait", 32'(s_htrans), 32'h0);
    tick();
    s_hready = 1'b1;
    settle();
    chk("t2_m0_hready_done", 32'(m0_hready), 32'h1);
    tick();

    // 3. same-cycle contention from reset: M0 wins first tie
    do_reset();
    m0_haddr = 32'h10; m0_htrans = 2'b10; m0_hwrite = 1'b0;
    m1_haddr = 32'h20; m1_htrans = 2'b10; m1_hwrite = 1'b1;
    settle();
    chk("t3_first_haddr", s_haddr, 32'h10);
    chk("t3_first_hwrite", 32'(s_hwrite), 32'h0);
    tick();
    m0_htrans = 2'b00; m1_htrans = 2'b00; m1_haddr = 32'hFFF0;
    m1_hwdata = 32'hCAFE_F00D; m0_hwdata = 32'h1111_1111;
    settle();
    chk("t3_m1_hready_pend", 32'(m1_hready), 32'h0);
    chk("t3_second_haddr", s_haddr, 32'h20);
    chk("t3_second_hwrite", 32'(s_hwrite), 32'h1);
    chk("t3_second_htrans", 32'(s_htrans), 32'h2);
    tick();
    settle();
    chk("t3_hwdata", s_hwdata, 32'hCAFE_F00D);
    chk("t3_m1_hready_data", 32'(m1_hready), 32'h1);
    tick();
    m1_hwrite = 1'b0;

    // 4. m1_lock with M0 streaming and M1 every 3rd cycle
    begin
      logic [31:0] exp_addr [6] = '{32'h2000, 32'h1000, 32'h1004,
                                    32'h2004, 32'h1008, 32'h100C};
      logic        exp_rdy  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] m0_next;
      logic        rdy;
      m1_lock = 1'b1;
      m0_next = 32'h1000;
      for (int i = 0; i < 6; i++) begin
        m0_haddr  = m0_next;
        m0_htrans = 2'b10;
        m1_htrans = (i % 3 == 0) ? 2'b10 : 2'b00;
        m1_haddr  = 32'h2000 + 32'(4 * (i / 3));
        settle();
        chk($sformatf("t4_haddr_%0d", i), s_haddr, exp_addr[i]);
        chk($sformatf("t4_m0_hready_%0d", i), 32'(m0_hready), 32'(exp_rdy[i]));
        rdy = m0_hready;
        tick();
        if (rdy) m0_next = m0_next + 32'h4;
      end
      m0_htrans = 2'b00; m1_htrans = 2'b00; m1_lock = 1'b0;
      tick();
      tick();
    end

    // 5. bus stalled for 4 cycles while M1 pends
    s_hready = 1'b0;
    m1_haddr = 32'h300; m1_hwrite = 1'b1; m1_htrans = 2'b10;
    settle();
    chk("t5_m1_hready_accept", 32'(m1_hready), 32'h1);
    chk("t5_htrans_stall0", 32'(s_htrans), 32'h0);
    tick();
    m1_htrans = 2'b00; m1_haddr = 32'hABC0;
    for (int i = 1; i < 4; i++) begin
      settle();
      chk($sformatf("t5_haddr_hold_%0d", i), s_haddr, 32'h100C);
      chk($sformatf("t5_m1_pend_%0d", i), 32'(m1_hready), 32'h0);
      tick();
    end
    s_hready = 1'b1;
    settle();
    chk("t5_issue_haddr", s_haddr, 32'h300);
    chk("t5_issue_htrans", 32'(s_htrans), 32'h2);
    chk("t5_issue_hwrite", 32'(s_hwrite), 32'h1);
    tick();
    settle();
    chk("t5_m1_hready_data", 32'(m1_hready), 32'h1);
    tick();
    m1_hwrite = 1'b0;
    tick();

    // 6. M0 takes a two-cycle ERROR while M1 pends
    m0_haddr = 32'h400; m0_htrans = 2'b10;
    settle();
    chk("t6_m0_haddr", s_haddr, 32'h400);
    tick();
    m0_htrans = 2'b00;
    m1_haddr = 32'h500; m1_htrans = 2'b10;
    s_hready = 1'b0; s_hresp = 1'b1;
    settle();
    chk("t6_err1_m0_hresp", 32'(m0_hresp), 32'h1);
    chk("t6_err1_m1_hresp", 32'(m1_hresp), 32'h0);
    chk("t6_err1_m0_hready", 32'(m0_hready), 32'h0);
    tick();
    m1_htrans = 2'b00; m1_haddr = 32'h0;
    s_hready = 1'b1; s_hresp = 1'b1;
    settle();
    chk("t6_err2_m0_hresp", 32'(m0_hresp), 32'h1);
    chk("t6_err2_m0_hready", 32'(m0_hready), 32'h1);
    chk("t6_err2_m1_hresp", 32'(m1_hresp), 32'h0);
    chk("t6_err2_m1_hready", 32'(m1_hready), 32'h0);
    chk("t6_m1_haddr", s_haddr, 32'h500);
    chk("t6_m1_htrans", 32'(s_htrans), 32'h2);
    tick();
    s_hresp = 1'b0; s_hrdata = 32'hBEEF_0002;
    settle();
    chk("t6_m1_hready", 32'(m1_hready), 32'h1);
    chk("t6_m1_hresp", 32'(m1_hresp), 32'h0);
    chk("t6_m1_hrdata", m1_hrdata, 32'hBEEF_0002);
    chk("t6_m0_hresp_after", 32'(m0_hresp), 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
